// File: rtl/mips_datapath_alu_hilo_seq.sv
// HI/LO unit: single-edge MULU/MULS/MTHI/MTLO, multi-cycle radix-2 restoring divide.
// Latency: mul/move write HI/LO at the issue edge; divide writes at DATA_W+2 edges from start.
// Backpressure: stall = busy & (start | read_req); starts while busy are ignored.
// Optional: MIPS_DATAPATH_ALU_HILO_SEQ_SIGNED_DIV_EN enables signed DIVS (otherwise DIVS == DIVU).
module mips_datapath_alu_hilo_seq #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W),
    parameter int FUNC_W  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [FUNC_W-1:0] func,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              read_req,
    input  logic              read_sel,
    output logic [DATA_W-1:0] read_data,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam logic [FUNC_W-1:0] FN_MULU = FUNC_W'(8);
    localparam logic [FUNC_W-1:0] FN_MULS = FUNC_W'(9);
    localparam logic [FUNC_W-1:0] FN_MTHI = FUNC_W'(10);
    localparam logic [FUNC_W-1:0] FN_MTLO = FUNC_W'(11);
    localparam logic [FUNC_W-1:0] FN_DIVU = FUNC_W'(12);
    localparam logic [FUNC_W-1:0] FN_DIVS = FUNC_W'(13);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0]  quo_q, quo_d;
    logic [DATA_W-1:0]  dvs_q, dvs_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [DATA_W-1:0]  lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
`ifdef MIPS_DATAPATH_ALU_HILO_SEQ_SIGNED_DIV_EN
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               sdiv;
`endif

    logic [2*DATA_W-1:0] prod_u;
    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W:0]     shifted;

    // Full-width products; signed form sign-extends operands so the low 2*DATA_W bits are exact
    assign prod_u  = {{DATA_W{1'b0}}, data1} * {{DATA_W{1'b0}}, data2};
    assign prod_s  = {{DATA_W{data1[DATA_W-1]}}, data1} * {{DATA_W{data2[DATA_W-1]}}, data2};
    // Partial remainder with the next dividend bit shifted in
    assign shifted = {rem_q, quo_q[DATA_W-1]};

    assign busy      = (state_q != ST_IDLE);
    assign stall     = busy & (start | read_req);
    assign done      = done_q;
    assign div_zero  = dz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign read_data = read_sel ? hi_q : lo_q;

    // Next-state: op issue in IDLE, one restoring step per DIV cycle, sign fix-up and writeback in FIX
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
`ifdef MIPS_DATAPATH_ALU_HILO_SEQ_SIGNED_DIV_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        sdiv    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (func)
                        FN_MULU: {hi_d, lo_d} = prod_u;
                        FN_MULS: {hi_d, lo_d} = prod_s;
                        FN_MTHI: hi_d = data1;
                        FN_MTLO: lo_d = data1;
                        FN_DIVU, FN_DIVS: begin
                            state_d = ST_DIV;
                            cnt_d   = '0;
                            rem_d   = '0;
`ifdef MIPS_DATAPATH_ALU_HILO_SEQ_SIGNED_DIV_EN
                            // Divide magnitudes; remember result signs for the FIX step
                            sdiv   = (func == FN_DIVS);
                            quo_d  = (sdiv && data1[DATA_W-1]) ? -data1 : data1;
                            dvs_d  = (sdiv && data2[DATA_W-1]) ? -data2 : data2;
                            qneg_d = sdiv && (data1[DATA_W-1] ^ data2[DATA_W-1]);
                            rneg_d = sdiv && data1[DATA_W-1];
`else
                            quo_d  = data1;
                            dvs_d  = data2;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_DIV: begin
                // Divisor 0 always "fits": quotient becomes all ones, remainder the dividend
                if (shifted >= {1'b0, dvs_q}) begin
                    rem_d = shifted[DATA_W-1:0] - dvs_q;
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = shifted[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end
                if (cnt_q == SHAMT_W'(DATA_W - 1)) begin
                    state_d = ST_FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SHAMT_W'(1);
                end
            end
            ST_FIX: begin
`ifdef MIPS_DATAPATH_ALU_HILO_SEQ_SIGNED_DIV_EN
                lo_d = qneg_q ? -quo_q : quo_q;
                hi_d = rneg_q ? -rem_q : rem_q;
`else
                lo_d = quo_q;
                hi_d = rem_q;
`endif
                done_d  = 1'b1;
                dz_d    = (dvs_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any divide in flight without touching HI/LO beyond clearing
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
`ifdef MIPS_DATAPATH_ALU_HILO_SEQ_SIGNED_DIV_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
`ifdef MIPS_DATAPATH_ALU_HILO_SEQ_SIGNED_DIV_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

endmodule
